// File: rtl/spi_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_apb_sequencer
// Brief    : Round-robin arbiter and APB master sharing one CORESPI between
//            NREQ requesters; one full-duplex byte transfer per grant.
// Revision : 1.0
// ============================================================================
module spi_apb_sequencer #(
  parameter int          NREQ        = 4,
  parameter logic [6:0]  ADDR_SSEL   = 7'h18,
  parameter logic [6:0]  ADDR_TXDATA = 7'h0C,
  parameter logic [6:0]  ADDR_RXDATA = 7'h08,
  parameter logic [15:0] TIMEOUT     = 16'd1023
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_txdata,
  input  logic [8*NREQ-1:0] req_ss,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rx_data,
  output logic              err,
  output logic              busy,
  output logic [6:0]        PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY,
  input  logic              SPIRXAVAIL
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_SS_SETUP  = 4'd1,
    S_SS_ACCESS = 4'd2,
    S_TX_SETUP  = 4'd3,
    S_TX_ACCESS = 4'd4,
    S_WAIT_RX   = 4'd5,
    S_RX_SETUP  = 4'd6,
    S_RX_ACCESS = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [IW-1:0] r_rr;
  logic [IW-1:0] r_gnt;
  logic [7:0]  r_tx;
  logic [7:0]  r_ss;
  logic [7:0]  r_shadow;
  logic [7:0]  r_rx;
  logic [15:0] r_cnt;
  logic        r_err;

  logic [7:0]    w_tx_arr [NREQ];
  logic [7:0]    w_ss_arr [NREQ];
  logic          w_gnt_vld;
  logic [IW-1:0] w_gnt_idx;
  logic [IW:0]   w_cand;
  logic [IW-1:0] w_rr_next;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_tx_arr[gi] = req_txdata[8*gi +: 8];
    assign w_ss_arr[gi] = req_ss[8*gi +: 8];
  end

  // First set request at or after the rr pointer, wrapping at NREQ.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_rr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(NREQ)) w_cand = w_cand - (IW+1)'(NREQ);
      if (!w_gnt_vld && req[w_cand[IW-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IW-1:0];
      end
    end
  end

  assign w_rr_next = (w_gnt_idx == IW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_next  = r_state;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld)
          w_next = (w_ss_arr[w_gnt_idx] != r_shadow) ? S_SS_SETUP : S_TX_SETUP;
      end
      S_SS_SETUP, S_SS_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_SS_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = ADDR_SSEL;
        PWDATA  = r_ss;
        if (r_state == S_SS_SETUP) w_next = S_SS_ACCESS;
        else if (PREADY)           w_next = S_TX_SETUP;
      end
      S_TX_SETUP, S_TX_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_TX_ACCESS);
        PWRITE  = 1'b1;
        PADDR   = ADDR_TXDATA;
        PWDATA  = r_tx;
        if (r_state == S_TX_SETUP) w_next = S_TX_ACCESS;
        else if (PREADY)           w_next = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        if (SPIRXAVAIL)            w_next = S_RX_SETUP;
        else if (r_cnt == TIMEOUT) w_next = S_DONE;
      end
      S_RX_SETUP, S_RX_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = (r_state == S_RX_ACCESS);
        PADDR   = ADDR_RXDATA;
        if (r_state == S_RX_SETUP) w_next = S_RX_ACCESS;
        else if (PREADY)           w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_rr     <= '0;
      r_gnt    <= '0;
      r_tx     <= '0;
      r_ss     <= '0;
      r_shadow <= '0;
      r_rx     <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_tx  <= w_tx_arr[w_gnt_idx];
            r_ss  <= w_ss_arr[w_gnt_idx];
            r_gnt <= w_gnt_idx;
            r_rr  <= w_rr_next;
            r_err <= 1'b0;
          end
        end
        S_SS_ACCESS: if (PREADY) r_shadow <= r_ss;
        S_TX_ACCESS: if (PREADY) r_cnt <= '0;
        S_WAIT_RX: begin
          r_cnt <= r_cnt + 16'd1;
          // A late SPIRXAVAIL still wins over the timeout in the same cycle.
          if (!SPIRXAVAIL && (r_cnt == TIMEOUT)) begin
            r_err <= 1'b1;
            r_rx  <= 8'h00;
          end
        end
        S_RX_ACCESS: if (PREADY) r_rx <= PRDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++)
      ack[i] = (r_state == S_DONE) && (r_gnt == IW'(i));
  end

  assign err     = (r_state == S_DONE) && r_err;
  assign busy    = (r_state != S_IDLE);
  assign rx_data = r_rx;

endmodule
`default_nettype wire
